// File: rtl/majority_sampler_rx.sv
// Oversampling UART bit detector: synchronises the serial line, finds the start edge,
// majority-votes a centred window of samples per bit cell and flags noise, false starts and stop errors.
module majority_sampler_rx #(
    parameter int SAMPLES     = 16,
    parameter int WINDOW      = 3,
    parameter int FRAME_BITS  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_data,
    input  logic                          i_baudclk,
    output logic                          o_valid,
    output logic                          o_bit,
    output logic [$clog2(FRAME_BITS)-1:0] o_bitindex,
    output logic                          o_onedetected,
    output logic                          o_zerodetected,
    output logic                          o_noise,
    output logic                          o_false_start,
    output logic                          o_frame_err,
    output logic                          o_busy
);

    localparam int TW     = $clog2(SAMPLES);
    localparam int BW     = $clog2(FRAME_BITS);
    localparam int CW     = $clog2(WINDOW + 1);
    localparam int WSTART = SAMPLES / 2 - WINDOW / 2;
    localparam int WEND   = WSTART + WINDOW - 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_prev;
    logic [TW-1:0]          r_tick;
    logic [BW-1:0]          r_bitcnt;
    logic [WINDOW-1:0]      r_win;

    logic                   r_valid, r_bit, r_one, r_zero, r_noise, r_fs, r_ferr;
    logic [BW-1:0]          r_idx;

    logic                   w_s;
    logic [TW-1:0]          w_tick_nxt;
    logic                   w_wrap, w_in_win, w_wend, w_last;
    logic [WINDOW-1:0]      w_win_full;
    logic [CW-1:0]          w_ones;
    logic                   w_maj, w_dec, w_fs, w_ferr;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_tick_nxt = (r_tick == TW'(SAMPLES - 1)) ? '0 : r_tick + TW'(1);
    assign w_wrap     = (w_tick_nxt == '0);
    assign w_in_win   = (w_tick_nxt >= TW'(WSTART)) && (w_tick_nxt <= TW'(WEND));
    assign w_wend     = (w_tick_nxt == TW'(WEND));
    assign w_last     = (r_bitcnt == BW'(FRAME_BITS - 1));
    // The vote includes the sample arriving on the WEND tick itself.
    assign w_win_full = WINDOW'({r_win, w_s});

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WINDOW; i++) begin
            w_ones = w_ones + CW'(w_win_full[i]);
        end
    end

    assign w_maj = (({1'b0, w_ones}) << 1) > (CW + 1)'(WINDOW);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_prev   <= 1'b1;
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_win    <= '0;
        end else if (i_baudclk) begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_prev   <= w_s;
                r_tick   <= '0;
                r_bitcnt <= '0;
            end else begin
                r_tick <= w_tick_nxt;
                if (w_wrap) r_bitcnt <= r_bitcnt + BW'(1);
                if (w_in_win) r_win <= w_win_full;
                // A false start re-arms edge hunting; a stop exit leaves prev tracking the line.
                if (w_state_nxt == S_IDLE) r_prev <= (r_state == S_START) ? 1'b1 : w_s;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_baudclk) begin
            case (r_state)
                S_IDLE:  if (!w_s && r_prev) w_state_nxt = S_START;
                S_START: if (w_wend) w_state_nxt = w_maj ? S_IDLE : S_DATA;
                S_DATA:  if (w_wend && w_last) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dec  = i_baudclk && w_wend &&
                 ((r_state == S_DATA) || ((r_state == S_START) && !w_maj));
        w_fs   = i_baudclk && w_wend && (r_state == S_START) && w_maj;
        w_ferr = i_baudclk && w_wend && (r_state == S_DATA) && w_last && !w_maj;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_idx   <= '0;
            r_one   <= 1'b0;
            r_zero  <= 1'b0;
            r_noise <= 1'b0;
            r_fs    <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_dec;
            r_one   <= w_dec && (w_ones == CW'(WINDOW));
            r_zero  <= w_dec && (w_ones == '0);
            r_noise <= w_dec && (w_ones != CW'(WINDOW)) && (w_ones != '0);
            r_fs    <= w_fs;
            r_ferr  <= w_ferr;
            if (w_dec) begin
                r_bit <= w_maj;
                r_idx <= r_bitcnt;
            end
        end
    end

    assign o_valid        = r_valid;
    assign o_bit          = r_bit;
    assign o_bitindex     = r_idx;
    assign o_onedetected  = r_one;
    assign o_zerodetected = r_zero;
    assign o_noise        = r_noise;
    assign o_false_start  = r_fs;
    assign o_frame_err    = r_ferr;
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_majority_sampler_rx.sv
// Directed bench for majority_sampler_rx: expected decisions are queued as cells are driven
// and compared by a monitor when o_valid pulses.
module tb_majority_sampler_rx;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_data = 1'b1;
    logic       i_baudclk = 1'b0;
    logic       o_valid, o_bit, o_onedetected, o_zerodetected, o_noise;
    logic       o_false_start, o_frame_err, o_busy;
    logic [3:0] o_bitindex;

    typedef struct packed {
        logic       b;
        logic [3:0] idx;
        logic       one;
        logic       zero;
        logic       noise;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   fs_seen = 0;
    int   fs_exp = 0;

    majority_sampler_rx dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_data         (i_data),
        .i_baudclk      (i_baudclk),
        .o_valid        (o_valid),
        .o_bit          (o_bit),
        .o_bitindex     (o_bitindex),
        .o_onedetected  (o_onedetected),
        .o_zerodetected (o_zerodetected),
        .o_noise        (o_noise),
        .o_false_start  (o_false_start),
        .o_frame_err    (o_frame_err),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick period: line value held 4 clocks, tick on the last one.
    task automatic tk(input logic d);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_data    = d;
            i_baudclk = (k == 3);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tk(1'b1);
    endtask

    task automatic send_cell(input logic d, input int flip_tick);
        for (int t = 0; t < 16; t++) tk((t == flip_tick) ? ~d : d);
    endtask

    task automatic push_exp(input int idx, input logic d, input logic noisy);
        exp_t e;
        e.b     = d;
        e.idx   = 4'(idx);
        e.one   = noisy ? 1'b0 : d;
        e.zero  = noisy ? 1'b0 : ~d;
        e.noise = noisy;
        e.ferr  = (idx == 9) && !d;
        q.push_back(e);
    endtask

    function automatic logic [9:0] frame_bits(input logic [7:0] b, input logic stopv);
        return {stopv, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input int noise_idx, input logic stopv);
        logic [9:0] bits;
        bits = frame_bits(b, stopv);
        for (int i = 0; i < 10; i++) begin
            push_exp(i, bits[i], i == noise_idx);
            send_cell(bits[i], (i == noise_idx) ? 8 : -1);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {o_valid, o_bit, o_bitindex, o_onedetected, o_zerodetected, o_noise,
                o_false_start, o_frame_err, o_busy};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_false_start) fs_seen++;
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", {28'd0, o_bitindex}, 32'hFFFF);
                end else begin
                    e = q.pop_front();
                    check($sformatf("dec%0d", e.idx),
                          {o_bit, o_bitindex, o_onedetected, o_zerodetected, o_noise, o_frame_err},
                          e);
                end
            end else if (o_onedetected || o_zerodetected || o_noise || o_frame_err) begin
                check("flag_without_valid",
                      {o_onedetected, o_zerodetected, o_noise, o_frame_err}, 0);
            end
        end
    end

    initial begin : stim
        logic [9:0] bits;

        // Reset held 3 cycles with the line toggling and ticks present.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outs", all_outs(), 0);
            i_data    = ~i_data;
            i_baudclk = 1'b1;
        end
        @(negedge clk);
        i_rst     = 1'b0;
        i_data    = 1'b1;
        i_baudclk = 1'b0;
        idle(20);
        check("idle_busy", o_busy, 0);
        check("idle_queue", q.size(), 0);

        // Clean 0xA5 frame.
        send_frame(8'hA5, -1, 1'b1);
        check("a5_hold_idx", o_bitindex, 9);
        check("a5_busy", o_busy, 0);
        idle(4);

        // Glitch: low for ticks 0-1 only.
        fs_exp++;
        tk(1'b0);
        tk(1'b0);
        idle(14);
        check("glitch_fs", fs_seen, fs_exp);
        check("glitch_busy", o_busy, 0);
        idle(4);

        send_frame(8'h3C, -1, 1'b1);
        idle(4);

        // Noise on tick 8 of bit index 3.
        send_frame(8'hA5, 3, 1'b1);
        idle(4);

        // Stop cell held low.
        send_frame(8'hFF, -1, 1'b0);
        check("stop_busy", o_busy, 0);
        idle(4);

        // Mid-frame reset during bit index 4.
        bits = frame_bits(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_exp(i, bits[i], 1'b0);
            send_cell(bits[i], -1);
        end
        for (int t = 0; t < 4; t++) tk(bits[4]);
        @(negedge clk);
        i_rst     = 1'b1;
        i_baudclk = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        check("midrst_outs", all_outs(), 0);
        idle(20);
        check("midrst_queue", q.size(), 0);

        send_frame(8'h81, -1, 1'b1);
        idle(4);

        check("final_queue", q.size(), 0);
        check("final_fs", fs_seen, fs_exp);
        check("final_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
